// File: rtl/aes_word_buffer.sv
// Word/block buffer between the HWPE streamers and the AES core: gathers four plaintext
// words into a block and scatters each ciphertext block back out as four words.
`timescale 1ns/1ps

module aes_word_buffer #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned N_WORDS        = 4,
  parameter bit          FIRST_WORD_MSB = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  // plaintext word stream in
  input  logic                        pt_valid_i,
  output logic                        pt_ready_o,
  input  logic [WORD_W-1:0]           pt_data_i,
  // plaintext block to the core
  output logic                        blk_valid_o,
  input  logic                        blk_ready_i,
  output logic [WORD_W*N_WORDS-1:0]   blk_data_o,
  // ciphertext block from the core
  input  logic                        ct_valid_i,
  output logic                        ct_ready_o,
  input  logic [WORD_W*N_WORDS-1:0]   ct_data_i,
  // ciphertext word stream out
  output logic                        cw_valid_o,
  input  logic                        cw_ready_i,
  output logic [WORD_W-1:0]           cw_data_o,
  // status
  output logic [1:0]                  gather_cnt_o,
  output logic [1:0]                  scatter_cnt_o,
  output logic [CNT_W-1:0]            blk_done_o,
  output logic                        idle_o
);

  localparam logic GFill  = 1'b0;
  localparam logic GFull  = 1'b1;
  localparam logic SEmpty = 1'b0;
  localparam logic SDrain = 1'b1;

  // Block held as N_WORDS packed words; element N_WORDS-1 occupies the top bits.
  logic [N_WORDS-1:0][WORD_W-1:0] gdata_q, gdata_d;
  logic [N_WORDS-1:0][WORD_W-1:0] sdata_q, sdata_d;

  logic             gstate_q, gstate_d;
  logic [1:0]       gcnt_q, gcnt_d;
  logic             sstate_q, sstate_d;
  logic [1:0]       scnt_q, scnt_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic [1:0] gslot, sslot;

  // With four words, reversing the slot order is a bitwise inversion of the index.
  assign gslot = FIRST_WORD_MSB ? ~gcnt_q : gcnt_q;
  assign sslot = FIRST_WORD_MSB ? ~scnt_q : scnt_q;

  // Gather side
  always_comb begin
    gstate_d = gstate_q;
    gcnt_d   = gcnt_q;
    gdata_d  = gdata_q;
    unique case (gstate_q)
      GFill: begin
        if (pt_valid_i) begin
          gdata_d[gslot] = pt_data_i;
          gcnt_d         = gcnt_q + 2'd1;
          if (gcnt_q == 2'd3) begin
            gstate_d = GFull;
          end
        end
      end
      GFull: begin
        if (blk_ready_i) begin
          gstate_d = GFill;
        end
      end
    endcase
  end

  // Scatter side
  always_comb begin
    sstate_d = sstate_q;
    scnt_d   = scnt_q;
    sdata_d  = sdata_q;
    done_d   = done_q;
    unique case (sstate_q)
      SEmpty: begin
        if (ct_valid_i) begin
          sdata_d  = ct_data_i;
          scnt_d   = 2'd0;
          sstate_d = SDrain;
        end
      end
      SDrain: begin
        if (cw_ready_i) begin
          scnt_d = scnt_q + 2'd1;
          if (scnt_q == 2'd3) begin
            sstate_d = SEmpty;
            done_d   = done_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      gstate_q <= GFill;
      gcnt_q   <= '0;
      gdata_q  <= '0;
      sstate_q <= SEmpty;
      scnt_q   <= '0;
      sdata_q  <= '0;
      done_q   <= '0;
    end else begin
      gstate_q <= gstate_d;
      gcnt_q   <= gcnt_d;
      gdata_q  <= gdata_d;
      sstate_q <= sstate_d;
      scnt_q   <= scnt_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
    end
  end

  // All outputs come straight from registered state.
  assign pt_ready_o    = (gstate_q == GFill);
  assign blk_valid_o   = (gstate_q == GFull);
  assign blk_data_o    = gdata_q;
  assign ct_ready_o    = (sstate_q == SEmpty);
  assign cw_valid_o    = (sstate_q == SDrain);
  assign cw_data_o     = (sstate_q == SDrain) ? sdata_q[sslot] : '0;
  assign gather_cnt_o  = gcnt_q;
  assign scatter_cnt_o = scnt_q;
  assign blk_done_o    = done_q;
  assign idle_o        = (gstate_q == GFill) && (gcnt_q == 2'd0) && (sstate_q == SEmpty);

endmodule

// File: tb/tb_aes_word_buffer.sv
// Scoreboard bench for aes_word_buffer: an MSB-first instance and an LSB-first instance with a
// narrow done counter share all stimulus; a monitor checks both against queued expectations.
`timescale 1ns/1ps

module tb_aes_word_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, clear;
  logic         pt_valid_i, blk_ready_i, ct_valid_i, cw_ready_i;
  logic [31:0]  pt_data_i;
  logic [127:0] ct_data_i;

  logic         pt_ready_m, blk_valid_m, ct_ready_m, cw_valid_m, idle_m;
  logic [127:0] blk_data_m;
  logic [31:0]  cw_data_m;
  logic [1:0]   gcnt_m, scnt_m;
  logic [15:0]  done_m;

  logic         pt_ready_l, blk_valid_l, ct_ready_l, cw_valid_l, idle_l;
  logic [127:0] blk_data_l;
  logic [31:0]  cw_data_l;
  logic [1:0]   gcnt_l, scnt_l;
  logic [2:0]   done_l;

  aes_word_buffer #(.WORD_W(32), .N_WORDS(4), .FIRST_WORD_MSB(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_m), .pt_data_i(pt_data_i),
    .blk_valid_o(blk_valid_m), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_m),
    .ct_valid_i(ct_valid_i), .ct_ready_o(ct_ready_m), .ct_data_i(ct_data_i),
    .cw_valid_o(cw_valid_m), .cw_ready_i(cw_ready_i), .cw_data_o(cw_data_m),
    .gather_cnt_o(gcnt_m), .scatter_cnt_o(scnt_m), .blk_done_o(done_m), .idle_o(idle_m)
  );

  aes_word_buffer #(.WORD_W(32), .N_WORDS(4), .FIRST_WORD_MSB(1'b0), .CNT_W(3)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_l), .pt_data_i(pt_data_i),
    .blk_valid_o(blk_valid_l), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_l),
    .ct_valid_i(ct_valid_i), .ct_ready_o(ct_ready_l), .ct_data_i(ct_data_i),
    .cw_valid_o(cw_valid_l), .cw_ready_i(cw_ready_i), .cw_data_o(cw_data_l),
    .gather_cnt_o(gcnt_l), .scatter_cnt_o(scnt_l), .blk_done_o(done_l), .idle_o(idle_l)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rnd_run = 1'b0;

  logic [127:0] exp_blk_q[$];
  logic [31:0]  exp_cw_q[$];
  logic [31:0]  exp_cwl_q[$];
  logic [127:0] mon_blk;
  logic [31:0]  mon_w, mon_wl;

  logic [31:0] ct_words[4] = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] swap_words(input logic [127:0] b);
    return {b[31:0], b[63:32], b[95:64], b[127:96]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ct_exp(input logic [127:0] d);
    for (int i = 0; i < 4; i++) begin
      exp_cw_q.push_back(d[127-32*i -: 32]);
      exp_cwl_q.push_back(d[32*i +: 32]);
    end
  endtask

  // Callers are aligned just after a rising edge; ready is sampled on the falling edge.
  task automatic send_pt(input logic [31:0] w, input int gap);
    int n;
    logic hs;
    repeat (gap) step();
    pt_valid_i = 1'b1;
    pt_data_i  = w;
    n = 0;
    forever begin
      @(negedge clk);
      hs = pt_ready_m;
      step();
      if (hs) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL pt_timeout: got no ready expected ready within 2000 cycles");
        break;
      end
    end
    pt_valid_i = 1'b0;
  endtask

  task automatic send_ct(input logic [127:0] d, input int gap);
    int n;
    logic hs;
    repeat (gap) step();
    ct_valid_i = 1'b1;
    ct_data_i  = d;
    n = 0;
    forever begin
      @(negedge clk);
      hs = ct_ready_m;
      step();
      if (hs) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL ct_timeout: got no ready expected ready within 2000 cycles");
        break;
      end
    end
    ct_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_blk_q.size() != 0 || exp_cw_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    chk(nm, 32'(exp_blk_q.size() + exp_cw_q.size()), 0);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_pt_ready"}, 32'(pt_ready_m), 1);
    chk({tag, "_blk_valid"}, 32'(blk_valid_m), 0);
    chkb({tag, "_blk_data"}, blk_data_m, '0);
    chk({tag, "_ct_ready"}, 32'(ct_ready_m), 1);
    chk({tag, "_cw_valid"}, 32'(cw_valid_m), 0);
    chk({tag, "_cw_data"}, cw_data_m, 0);
    chk({tag, "_gather_cnt"}, 32'(gcnt_m), 0);
    chk({tag, "_scatter_cnt"}, 32'(scnt_m), 0);
    chk({tag, "_blk_done"}, 32'(done_m), 0);
    chk({tag, "_idle"}, 32'(idle_m), 1);
    chk({tag, "_blk_done_lsb"}, 32'(done_l), 0);
    chkb({tag, "_blk_data_lsb"}, blk_data_l, '0);
    step();
  endtask

  // Monitor: pops an expectation for every handshake on either output path.
  always @(negedge clk) begin
    if (blk_valid_m && blk_ready_i) begin
      if (exp_blk_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL blk_unexpected: got %h expected no block", blk_data_m);
      end else begin
        mon_blk = exp_blk_q.pop_front();
        chkb("blk_msb", blk_data_m, mon_blk);
        chkb("blk_lsb", blk_data_l, swap_words(mon_blk));
        chk("blk_valid_lsb", 32'(blk_valid_l), 1);
      end
    end
    if (cw_valid_m && cw_ready_i) begin
      if (exp_cw_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cw_unexpected: got %h expected no word", cw_data_m);
      end else begin
        mon_w  = exp_cw_q.pop_front();
        mon_wl = exp_cwl_q.pop_front();
        chk("cw_msb", cw_data_m, mon_w);
        chk("cw_lsb", cw_data_l, mon_wl);
      end
    end
  end

  initial begin
    int t0;
    reset_n = 1'b0; clear = 1'b0;
    pt_valid_i = 1'b0; pt_data_i = '0; blk_ready_i = 1'b0;
    ct_valid_i = 1'b0; ct_data_i = '0; cw_ready_i = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    check_reset("por");

    // Back-to-back gather of one block with the core ready
    blk_ready_i = 1'b1;
    exp_blk_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    t0 = cyc;
    send_pt(32'h00112233, 0);
    send_pt(32'h44556677, 0);
    send_pt(32'h8899AABB, 0);
    send_pt(32'hCCDDEEFF, 0);
    chk("gather_4_consecutive", 32'(cyc - t0), 4);
    @(negedge clk);
    chk("g_full_blk_valid", 32'(blk_valid_m), 1);
    chk("g_full_pt_ready", 32'(pt_ready_m), 0);
    chk("g_full_gather_cnt", 32'(gcnt_m), 0);
    step();
    @(negedge clk);
    chk("g_refill_pt_ready", 32'(pt_ready_m), 1);
    chk("g_refill_blk_valid", 32'(blk_valid_m), 0);
    step();

    // Scatter with sink stalled, then ready toggling 1,0,1,0...
    blk_ready_i = 1'b0;
    cw_ready_i  = 1'b0;
    push_ct_exp(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A);
    send_ct(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 0);
    @(negedge clk);
    chk("s_drain_cw_valid", 32'(cw_valid_m), 1);
    chk("s_drain_ct_ready", 32'(ct_ready_m), 0);
    chk("s_drain_first_word", cw_data_m, 32'h69C4E0D8);
    step();
    repeat (2) begin
      @(negedge clk);
      chk("cw_stall_hold_data", cw_data_m, 32'h69C4E0D8);
      chk("cw_stall_hold_idx", 32'(scnt_m), 0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      cw_ready_i = (i % 2 == 0);
      @(negedge clk);
      if (i % 2 == 1) begin
        chk("cw_toggle_valid", 32'(cw_valid_m), (i < 7) ? 1 : 0);
        chk("cw_toggle_idx", 32'(scnt_m), ((i + 1) / 2) % 4);
        if (i < 7) chk("cw_toggle_hold", cw_data_m, ct_words[(i+1)/2]);
      end
      step();
    end
    cw_ready_i = 1'b0;
    @(negedge clk);
    chk("s_done_ct_ready", 32'(ct_ready_m), 1);
    chk("s_done_cw_valid", 32'(cw_valid_m), 0);
    chk("blk_done_one", 32'(done_m), 1);
    chk("blk_done_one_lsb", 32'(done_l), 1);
    step();

    // Clear with a partial block and an undelivered ciphertext block in flight
    send_ct(128'hFEEDFACE_0BADF00D_CAFEBABE_DEADBEEF, 0);
    send_pt(32'hDEAD0001, 0);
    send_pt(32'hDEAD0002, 1);
    @(negedge clk);
    chk("partial_gather_cnt", 32'(gcnt_m), 2);
    chk("partial_idle", 32'(idle_m), 0);
    chk("partial_cw_valid", 32'(cw_valid_m), 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_gather_cnt", 32'(gcnt_m), 0);
    chk("clear_idle", 32'(idle_m), 1);
    chk("clear_blk_done", 32'(done_m), 0);
    chk("clear_cw_valid", 32'(cw_valid_m), 0);
    chk("clear_ct_ready", 32'(ct_ready_m), 1);
    chkb("clear_blk_data", blk_data_m, '0);
    step();
    blk_ready_i = 1'b1;
    exp_blk_q.push_back(128'h11111111_22222222_33333333_44444444);
    send_pt(32'h11111111, 0);
    send_pt(32'h22222222, 0);
    send_pt(32'h33333333, 2);
    send_pt(32'h44444444, 0);
    wait_drain("clear_block_drain");

    // Concurrent random traffic on both paths
    blk_ready_i = 1'b0;
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          blk_ready_i = 1'($urandom_range(0, 1));
          cw_ready_i  = 1'($urandom_range(0, 1));
          step();
        end
      end
    join_none
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          logic [31:0] w [4];
          for (int i = 0; i < 4; i++) w[i] = {4'(i), 12'h5A5, 16'(b)};
          exp_blk_q.push_back({w[0], w[1], w[2], w[3]});
          for (int i = 0; i < 4; i++) send_pt(w[i], int'($urandom_range(0, 2)));
        end
      end
      begin
        for (int b = 0; b < 1000; b++) begin
          logic [127:0] d;
          d = {32'(b) * 32'h9E3779B9, ~32'(b), 32'hC0DE0000 ^ 32'(b), 32'(b) << 3};
          push_ct_exp(d);
          send_ct(d, int'($urandom_range(0, 3)));
        end
      end
    join
    rnd_run = 1'b0;
    repeat (2) step();
    blk_ready_i = 1'b1;
    cw_ready_i  = 1'b1;
    wait_drain("random_drain");
    chk("blk_done_1000", 32'(done_m), 1000);
    chk("blk_done_wrap_lsb", 32'(done_l), 1000 % 8);

    // Reset while gather is full and scatter is draining
    blk_ready_i = 1'b0;
    cw_ready_i  = 1'b0;
    send_pt(32'hA0A0A0A0, 0);
    send_pt(32'hB1B1B1B1, 0);
    send_pt(32'hC2C2C2C2, 0);
    send_pt(32'hD3D3D3D3, 0);
    send_ct(128'h0123456789ABCDEF_FEDCBA9876543210, 0);
    @(negedge clk);
    chk("pre_reset_blk_valid", 32'(blk_valid_m), 1);
    chk("pre_reset_cw_valid", 32'(cw_valid_m), 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_reset("mid_reset");

    chk("blk_queue_empty", 32'(exp_blk_q.size()), 0);
    chk("cw_queue_empty", 32'(exp_cw_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
